// File: rtl/bus_pkg.sv
// bus_pkg: shared command type, issuer state encoding and default bus widths
package bus_pkg;
   localparam int ADDR_W = 8;
   localparam int DATA_W = 8;
   typedef struct packed {
      logic              write;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } bus_cmd_t;
   typedef enum logic [1:0] {IDLE, REQ, RSP} issuer_state_e;
endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo: synchronous power-of-2 FIFO of commands with occupancy count
module cmd_fifo #(
   parameter int  DEPTH = 4,
   parameter type T     = bus_pkg::bus_cmd_t
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push_i,
   input  logic                   pop_i,
   input  T                       din_i,
   output T                       dout_o,
   output logic [$clog2(DEPTH):0] count_o,
   output logic                   full_o,
   output logic                   empty_o
);
   localparam int PW = $clog2(DEPTH);
   T             mem_q [DEPTH];
   logic [PW-1:0] wr_q, rd_q;
   logic [PW:0]   cnt_q;
   logic          push, pop;
   assign full_o  = cnt_q[PW];
   assign empty_o = cnt_q == '0;
   assign push    = push_i && !full_o;
   assign pop     = pop_i && !empty_o;
   assign dout_o  = mem_q[rd_q];
   assign count_o = cnt_q;
   // storage array carries no reset; only the pointers and count define validity
   always_ff @(posedge clk)
      if (push) mem_q[wr_q] <= din_i;
   // pointers wrap naturally at DEPTH; count moves by push minus pop
   always_ff @(posedge clk)
      if (!rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push) wr_q <= wr_q + PW'(1);
         if (pop) rd_q <= rd_q + PW'(1);
         cnt_q <= cnt_q + (PW+1)'(push) - (PW+1)'(pop);
      end
endmodule

// File: rtl/bus_cmd_issuer.sv
// bus_cmd_issuer: buffers client commands and issues them one at a time over req/ack with timeout
module bus_cmd_issuer #(
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 8,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 15
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic                   in_write,
   input  logic [ADDR_W-1:0]      in_addr,
   input  logic [DATA_W-1:0]      in_wdata,
   output logic                   bus_req,
   output logic                   bus_write,
   output logic [ADDR_W-1:0]      bus_addr,
   output logic [DATA_W-1:0]      bus_wdata,
   input  logic                   bus_ack,
   input  logic [DATA_W-1:0]      bus_rdata,
   output logic                   rsp_valid,
   output logic [DATA_W-1:0]      rsp_data,
   output logic                   rsp_err,
   output logic [$clog2(DEPTH):0] count
);
   import bus_pkg::*;
   localparam int TW = $clog2(TIMEOUT + 1);
   typedef struct packed {
      logic              write;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } cmd_t;
   cmd_t              in_cmd, head, hold_q, hold_d;
   issuer_state_e     state_q, state_d;
   logic [TW-1:0]     timer_q, timer_d;
   logic              req_q, req_d, rv_q, rv_d, err_q, err_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              full, empty, pop;
   assign in_cmd    = '{write: in_write, addr: in_addr, wdata: in_wdata};
   assign in_ready  = !full;
   assign pop       = state_q == IDLE && !empty;
   assign bus_req   = req_q;
   assign bus_write = hold_q.write;
   assign bus_addr  = hold_q.addr;
   assign bus_wdata = hold_q.wdata;
   assign rsp_valid = rv_q;
   assign rsp_data  = rdata_q;
   assign rsp_err   = err_q;
   cmd_fifo #(.DEPTH(DEPTH), .T(cmd_t)) u_fifo (
      .clk,
      .rst,
      .push_i (in_valid && in_ready),
      .pop_i  (pop),
      .din_i  (in_cmd),
      .dout_o (head),
      .count_o(count),
      .full_o (full),
      .empty_o(empty)
   );
   // next state: pop into holding regs, wait for ack or timeout, then one response strobe
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      hold_d  = hold_q;
      req_d   = req_q;
      rv_d    = 1'b0;
      err_d   = err_q;
      rdata_d = rdata_q;
      case (state_q)
         IDLE: if (!empty) begin
            hold_d  = head;
            req_d   = 1'b1;
            timer_d = '0;
            state_d = REQ;
         end
         REQ: if (bus_ack || timer_q == TW'(TIMEOUT - 1)) begin
            req_d   = 1'b0;
            rv_d    = 1'b1;
            err_d   = !bus_ack;
            rdata_d = (bus_ack && !hold_q.write) ? bus_rdata : '0;
            state_d = RSP;
         end else timer_d = timer_q + TW'(1);
         default: state_d = IDLE;
      endcase
   end
   // state and registered outputs, cleared by active-low synchronous reset
   always_ff @(posedge clk)
      if (!rst) begin
         state_q <= IDLE;
         timer_q <= '0;
         hold_q  <= '0;
         req_q   <= 1'b0;
         rv_q    <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         hold_q  <= hold_d;
         req_q   <= req_d;
         rv_q    <= rv_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
endmodule

// File: tb/tb_bus_cmd_issuer.sv
// tb_bus_cmd_issuer: directed and random stimulus checked against a transaction-level model
module tb_bus_cmd_issuer;
   localparam int AW = 8, DW = 8, DEPTH = 4, TO = 15, CW = $clog2(DEPTH) + 1;
   logic          clk = 1'b0;
   logic          rst, in_valid, in_write, bus_ack;
   logic [AW-1:0] in_addr;
   logic [DW-1:0] in_wdata, bus_rdata;
   logic          in_ready, bus_req, bus_write, rsp_valid, rsp_err;
   logic [AW-1:0] bus_addr;
   logic [DW-1:0] bus_wdata, rsp_data;
   logic [CW-1:0] count;
   typedef struct {bit w; bit [AW-1:0] a; bit [DW-1:0] d;} cmd_s;
   cmd_s          q[$];
   cmd_s          cur, hold;
   bit            busy, e_req, e_rv, e_err;
   bit [DW-1:0]   e_rd;
   int            age, gap, checks, errors;

   always #5 clk = ~clk;

   bus_cmd_issuer #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_write(in_write),
      .in_addr(in_addr), .in_wdata(in_wdata), .bus_req(bus_req), .bus_write(bus_write),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .count(count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // one clock: drive inputs, advance the model across the edge, compare at the next negedge
   task automatic tick(input bit r, input bit v, input bit w, input bit [AW-1:0] a,
                       input bit [DW-1:0] d, input bit ack, input bit [DW-1:0] rd);
      int pre;
      rst = r; in_valid = v; in_write = w; in_addr = a; in_wdata = d; bus_ack = ack; bus_rdata = rd;
      if (!r) begin
         q.delete();
         busy = 0; age = 0; gap = 0; e_req = 0; e_rv = 0; e_err = 0; e_rd = 0;
         hold = '{0, 0, 0};
      end else begin
         pre = q.size();
         e_rv = 0;
         if (busy) begin
            age++;
            if (ack || age == TO) begin
               e_rv = 1; e_err = !ack; e_rd = (ack && !cur.w) ? rd : '0;
               busy = 0; e_req = 0; gap = 1;
            end
         end else if (gap > 0) gap--;
         else if (pre > 0) begin
            cur = q.pop_front(); hold = cur; busy = 1; age = 0; e_req = 1;
         end
         if (v && pre < DEPTH) q.push_back('{w, a, d});
      end
      @(negedge clk);
      chk("count", 32'(count), 32'(q.size()));
      chk("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
      chk("bus_req", 32'(bus_req), 32'(e_req));
      chk("bus_write", 32'(bus_write), 32'(hold.w));
      chk("bus_addr", 32'(bus_addr), 32'(hold.a));
      chk("bus_wdata", 32'(bus_wdata), 32'(hold.d));
      chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
      chk("rsp_data", 32'(rsp_data), 32'(e_rd));
      chk("rsp_err", 32'(rsp_err), 32'(e_err));
   endtask

   initial begin
      rst = 0; in_valid = 0; in_write = 0; in_addr = 0; in_wdata = 0; bus_ack = 0; bus_rdata = 0;
      @(negedge clk);
      tick(0, 0, 0, 0, 0, 0, 0);
      tick(0, 1, 1, 8'hFF, 8'hFF, 1, 8'hFF);
      // single read acked one cycle after bus_req
      tick(1, 1, 0, 8'h3C, 8'h00, 0, 0);
      for (int i = 0; i < 6; i++) tick(1, 0, 0, 0, 0, bus_req, 8'hA5);
      // single write
      tick(1, 1, 1, 8'h10, 8'h7E, 0, 0);
      for (int i = 0; i < 6; i++) tick(1, 0, 0, 0, 0, bus_req, 8'h5A);
      // fill with ack held low, then one rejected push while full
      for (int i = 0; i < 5; i++) tick(1, 1, i[0], AW'(i), DW'(8'h20 + i), 0, 0);
      tick(1, 1, 0, 8'hEE, 8'hEE, 0, 0);
      // ack in order while still offering pushes: exercises pop with count=4 and in_valid=1
      for (int i = 0; i < 40; i++) tick(1, i < 10, i[0], AW'(8'h40 + i), DW'(i), bus_req, DW'(i * 3 + 1));
      // timeout, then a normal command
      tick(1, 1, 0, 8'h77, 0, 0, 0);
      for (int i = 0; i < 20; i++) tick(1, 0, 0, 0, 0, 0, 8'h99);
      tick(1, 1, 0, 8'h78, 0, 0, 0);
      for (int i = 0; i < 6; i++) tick(1, 0, 0, 0, 0, bus_req, 8'h66);
      // reset while a command is in flight with two queued
      for (int i = 0; i < 3; i++) tick(1, 1, 0, AW'(8'h80 + i), 0, 0, 0);
      tick(0, 0, 0, 0, 0, 1, 8'h11);
      for (int i = 0; i < 3; i++) tick(1, 0, 0, 0, 0, 1, 8'h22);
      // random traffic: ack styles rotate between sparse, near-absent (timeouts) and noisy
      for (int i = 0; i < 3000; i++) begin
         bit ack;
         int ph;
         ph = (i / 400) % 3;
         if (ph == 0) ack = bus_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 5) == 0);
         else if (ph == 1) ack = $urandom_range(0, 39) == 0;
         else ack = $urandom_range(0, 1) == 1;
         tick($urandom_range(0, 199) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
              AW'($urandom), DW'($urandom), ack, DW'($urandom));
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/bus_cmd_issuer.md
Name: bus_cmd_issuer

Overview:
- Command front-end that sits directly upstream of the bus manager on the shared bus interface.
- Accepts read/write commands from a client over valid/ready and buffers them in a small FIFO.
- Issues buffered commands one at a time to the bus manager over a req/ack handshake.
- Returns one response per command, carrying read data or a timeout error flag.

Parameters:
- ADDR_W, 8, bus address width
- DATA_W, 8, bus data width
- DEPTH, 4, command FIFO entries (power of 2, >=2)
- TIMEOUT, 15, max cycles bus_req is held without ack before error (>=1)

Ports:
- clk  in  1  single clock, all logic on posedge
- rst  in  1  synchronous, active-low reset (rst==0 at posedge resets)
- in_valid  in  1  client command valid
- in_ready  out  1  FIFO can accept
- in_write  in  1  1=write, 0=read
- in_addr  in  ADDR_W  command address
- in_wdata  in  DATA_W  write data (ignored for reads)
- bus_req  out  1  command presented to bus manager
- bus_write  out  1  direction of presented command
- bus_addr  out  ADDR_W  presented address
- bus_wdata  out  DATA_W  presented write data
- bus_ack  in  1  bus manager accepted/completed command
- bus_rdata  in  DATA_W  read data, valid with bus_ack
- rsp_valid  out  1  one-cycle response strobe
- rsp_data  out  DATA_W  read data (0 for writes or on error)
- rsp_err  out  1  timeout occurred
- count  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (rst==0 at posedge): FIFO empty, count=0, state IDLE, timer=0. All registered outputs 0: bus_req, bus_write, bus_addr, bus_wdata, rsp_valid, rsp_data, rsp_err. in_ready=1 on the first cycle after reset.
- Reset mid-transaction: aborts it and flushes the FIFO. No response is produced for aborted or flushed commands.
- FIFO push:
  - Push occurs when in_valid && in_ready at posedge.
  - in_ready = (count < DEPTH), decoded from registered count only. A pop in the same cycle does not make a full FIFO ready.
  - Pointers wrap modulo DEPTH.
- FIFO pop: only on the IDLE->REQ transition. Simultaneous push and pop leaves count unchanged.
- FSM states IDLE, REQ, RSP:
  - IDLE: if count>0, pop head into holding regs (bus_write/addr/wdata), set bus_req=1, timer=0, go REQ. Else stay.
  - REQ: bus_req stays 1 and holding regs are stable.
    - bus_ack at posedge: bus_req=0, rsp_data=(read? bus_rdata : 0), rsp_err=0, rsp_valid=1, go RSP.
    - No ack and timer==TIMEOUT-1: bus_req=0, rsp_data=0, rsp_err=1, rsp_valid=1, go RSP.
    - Otherwise timer++.
  - RSP: rsp_valid=0 next edge, go IDLE. rsp_data and rsp_err hold until the next response.
- bus_ack outside REQ is ignored.
- Latency, push at edge N into empty FIFO:
  - bus_req rises after N+1.
  - With ack sampled at N+2, rsp_valid is high for the cycle after N+2.
  - The next queued command's bus_req rises after N+4.
- Minimum 3 cycles per command.
- On timeout, bus_req is high for exactly TIMEOUT cycles.
- No response back-pressure: the client must always accept rsp_valid.
- Commands complete strictly in FIFO order.

Decomposition:
- Shared package bus_pkg:
  - typedef bus_cmd_t struct {write, addr, wdata}
  - state enum issuer_state_e {IDLE, REQ, RSP}
  - default width constants ADDR_W/DATA_W
- One sub-module: cmd_fifo, a parameterised synchronous FIFO of bus_cmd_t with push/pop/count, full/empty. It uses the same clk and rst.

Test Plan:
- Single read: push read addr 0x3C. Bench acks 1 cycle after bus_req with rdata 0xA5. Expect rsp_valid one cycle, rsp_data=0xA5, rsp_err=0, bus_addr=0x3C while bus_req.
- Single write: push write addr 0x10 data 0x7E. Expect bus_write=1, bus_wdata=0x7E, rsp_data=0x00, rsp_err=0.
- Fill/back-pressure:
  - Hold bus_ack=0 and push 5 commands back-to-back.
  - Expect first popped, then count=4, in_ready=0, fifth held.
  - Then ack each; all 5 responses arrive in order with addresses 0..4.
- Timeout: TIMEOUT=15, never ack. Expect bus_req high exactly 15 cycles, then rsp_valid with rsp_err=1, rsp_data=0. Next command then issues normally.
- Simultaneous push/pop: count=4 at IDLE pop while in_valid=1. Expect no push that edge, count=3. Push accepted the following cycle, count=4.
- Reset mid-REQ: rst=0 for one posedge while bus_req=1 with 2 queued. Expect bus_req=0, count=0, no rsp_valid, in_ready=1 afterwards.
